// File: rtl/clock_pkg.sv
// Shared definitions for the clock chain: field-select encodings, BCD calendar
// constants and small BCD arithmetic helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    SEL_DAY   = 2'b00,
    SEL_MONTH = 2'b01,
    SEL_YEAR  = 2'b10,
    SEL_NONE  = 2'b11
  } sel_e;

  localparam logic [7:0] MONTH_JAN = 8'h01;
  localparam logic [7:0] MONTH_FEB = 8'h02;
  localparam logic [7:0] MONTH_APR = 8'h04;
  localparam logic [7:0] MONTH_JUN = 8'h06;
  localparam logic [7:0] MONTH_SEP = 8'h09;
  localparam logic [7:0] MONTH_NOV = 8'h11;
  localparam logic [7:0] MONTH_DEC = 8'h12;

  localparam logic [7:0] DAY_FIRST = 8'h01;
  localparam logic [7:0] DAYS_28   = 8'h28;
  localparam logic [7:0] DAYS_29   = 8'h29;
  localparam logic [7:0] DAYS_30   = 8'h30;
  localparam logic [7:0] DAYS_31   = 8'h31;

  localparam logic [7:0] RST_DAY      = DAY_FIRST;
  localparam logic [7:0] RST_MONTH    = MONTH_JAN;
  localparam logic [7:0] RST_YEAR_LOW = 8'h00;

  // Two-digit BCD value divisible by 4, decided on the digits directly.
  function automatic logic bcd_div4(input logic [3:0] ten, input logic [3:0] unit);
    if (ten[0]) return (unit == 4'd2) || (unit == 4'd6);
    else        return (unit == 4'd0) || (unit == 4'd4) || (unit == 4'd8);
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Four-digit ripple increment; 9999 wraps to 0000.
  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Four-digit ripple decrement; 0000 wraps to 9999.
  function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_date_if.sv
// Control and date bus of the calendar stage; master drives controls,
// slave (counter_date) returns the BCD date and the millennium pulse.
interface counter_date_if;
  logic       up;
  logic       down;
  logic       mode_date;
  logic [1:0] sel;
  logic       tick_day;
  logic [3:0] day_unit;
  logic [3:0] day_ten;
  logic [3:0] month_unit;
  logic [3:0] month_ten;
  logic [3:0] year_unit;
  logic [3:0] year_ten;
  logic [3:0] year_hund;
  logic [3:0] year_thou;
  logic       tick_millennium;

  modport master (
    output up, down, mode_date, sel, tick_day,
    input  day_unit, day_ten, month_unit, month_ten,
    input  year_unit, year_ten, year_hund, year_thou, tick_millennium
  );

  modport slave (
    input  up, down, mode_date, sel, tick_day,
    output day_unit, day_ten, month_unit, month_ten,
    output year_unit, year_ten, year_hund, year_thou, tick_millennium
  );
endinterface

// File: rtl/date_limit.sv
// Days-in-month lookup for a BCD month/year. Leap handling is present only
// when COUNTER_DATE_LEAP_YEAR_EN is defined; otherwise February is 28 days.
module date_limit
  import clock_pkg::*;
(
  input  logic [7:0]  month,
  input  logic [15:0] year,
  output logic [3:0]  mdays_ten,
  output logic [3:0]  mdays_unit,
  output logic        is_leap
);

`ifdef COUNTER_DATE_LEAP_YEAR_EN
  // Century years fall back to the thousands/hundreds pair (the /400 rule).
  assign is_leap = (year[7:0] == 8'h00) ? bcd_div4(year[15:12], year[11:8])
                                        : bcd_div4(year[7:4],   year[3:0]);
`else
  logic year_unused;
  assign year_unused = ^year;
  assign is_leap     = 1'b0;
`endif

  logic [7:0] mdays;

  always_comb begin
    case (month)
      MONTH_FEB:                              mdays = is_leap ? DAYS_29 : DAYS_28;
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: mdays = DAYS_30;
      default:                                mdays = DAYS_31;
    endcase
  end

  assign {mdays_ten, mdays_unit} = mdays;

endmodule

// File: rtl/counter_date.sv
// Calendar stage: BCD day/month/year with run (tick_day) and set (up/down) modes.
// Optional leap-year support via COUNTER_DATE_LEAP_YEAR_EN.
module counter_date
  import clock_pkg::*;
#(
  parameter logic [3:0] RST_YEAR_THOU = 4'd2,
  parameter logic [3:0] RST_YEAR_HUND = 4'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_date_if.slave    bus
);

  logic [7:0]  day_q,   day_pre, day_n;
  logic [7:0]  month_q, month_n;
  logic [15:0] year_q,  year_n;
  logic        tick_q,  tick_n;

  logic [7:0]  cur_mdays, adj_mdays;
  logic        cur_leap_unused, adj_leap_unused;
  logic        step_up, step_dn;

  // Limit for the date as it stands (day stepping, end-of-month rollover).
  date_limit u_cur_limit (
    .month      (month_q),
    .year       (year_q),
    .mdays_ten  (cur_mdays[7:4]),
    .mdays_unit (cur_mdays[3:0]),
    .is_leap    (cur_leap_unused)
  );

  // Limit for the month/year about to be registered, used to clamp the day.
  date_limit u_adj_limit (
    .month      (month_n),
    .year       (year_n),
    .mdays_ten  (adj_mdays[7:4]),
    .mdays_unit (adj_mdays[3:0]),
    .is_leap    (adj_leap_unused)
  );

  assign step_up = bus.up & ~bus.down;
  assign step_dn = bus.down & ~bus.up;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    day_pre = day_q;
    month_n = month_q;
    year_n  = year_q;
    tick_n  = 1'b0;
    if (bus.mode_date) begin
      if (bus.tick_day) begin
        if (day_q == cur_mdays) begin
          day_pre = DAY_FIRST;
          if (month_q == MONTH_DEC) begin
            month_n = MONTH_JAN;
            year_n  = bcd4_inc(year_q);
            tick_n  = (year_n[15:12] != year_q[15:12]);
          end else begin
            month_n = bcd2_inc(month_q);
          end
        end else begin
          day_pre = bcd2_inc(day_q);
        end
      end
    end else if (step_up || step_dn) begin
      case (sel_e'(bus.sel))
        SEL_DAY: begin
          if (step_up) day_pre = (day_q == cur_mdays) ? DAY_FIRST : bcd2_inc(day_q);
          else         day_pre = (day_q == DAY_FIRST) ? cur_mdays : bcd2_dec(day_q);
        end
        SEL_MONTH: begin
          if (step_up) month_n = (month_q == MONTH_DEC) ? MONTH_JAN : bcd2_inc(month_q);
          else         month_n = (month_q == MONTH_JAN) ? MONTH_DEC : bcd2_dec(month_q);
        end
        SEL_YEAR: year_n = step_up ? bcd4_inc(year_q) : bcd4_dec(year_q);
        SEL_NONE: ;
      endcase
    end
  end

  // Valid BCD compares correctly as plain binary.
  assign day_n = (day_pre > adj_mdays) ? adj_mdays : day_pre;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q   <= RST_DAY;
      month_q <= RST_MONTH;
      year_q  <= {RST_YEAR_THOU, RST_YEAR_HUND, RST_YEAR_LOW};
      tick_q  <= 1'b0;
    end else begin
      day_q   <= day_n;
      month_q <= month_n;
      year_q  <= year_n;
      tick_q  <= tick_n;
    end
  end

  assign bus.day_ten         = day_q[7:4];
  assign bus.day_unit        = day_q[3:0];
  assign bus.month_ten       = month_q[7:4];
  assign bus.month_unit      = month_q[3:0];
  assign bus.year_thou       = year_q[15:12];
  assign bus.year_hund       = year_q[11:8];
  assign bus.year_ten        = year_q[7:4];
  assign bus.year_unit       = year_q[3:0];
  assign bus.tick_millennium = tick_q;

endmodule

// File: doc/counter_date.md
Name: counter_date

Overview:
- Calendar stage of the clock chain. Consumes the one-cycle `tick_day` pulse produced by the hours counter.
- Maintains a BCD date: day, month and a 4-digit year (0000–9999).
- Emits a one-cycle `tick_millennium` pulse when the thousands digit of the year advances.
- In set mode, up/down adjust one selected field with calendar-correct wrap and clamping.

Parameters:
- RST_YEAR_THOU, 4'd2, reset value of the year thousands digit.
- RST_YEAR_HUND, 4'd0, reset value of the year hundreds digit.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; active-low, asynchronous
- up  input  1  set-mode increment, level; one step per clock while high
- down  input  1  set-mode decrement, level; one step per clock while high
- mode_date  input  1  1 = run (follow tick_day), 0 = set (up/down active)
- sel  input  2  set-mode field: 00 = day, 01 = month, 10 = year, 11 = none
- tick_day  input  1  one-cycle pulse, advance date by one day
- day_unit, day_ten  output  4 each  BCD day, 01..31
- month_unit, month_ten  output  4 each  BCD month, 01..12
- year_unit, year_ten, year_hund, year_thou  output  4 each  BCD year
- tick_millennium  output  1  registered one-cycle pulse

Behaviour:
- Reset: outputs are registers.
  - Date = 01-01-(RST_YEAR_THOU)(RST_YEAR_HUND)00; default 01-01-2000.
  - tick_millennium = 0.
- Days-in-month (mdays):
  - Months 01, 03, 05, 07, 08, 10, 12: 31.
  - Months 04, 06, 09, 11: 30.
  - Month 02: 29 if leap, else 28.
- Leap rule: year divisible by 4 and (not divisible by 100 or divisible by 400), evaluated on BCD digits.
  - Two BCD digits are divisible by 4 iff (ten even and unit ∈ {0, 4, 8}) or (ten odd and unit ∈ {2, 6}).
  - If year_ten:year_unit == 00, apply the same test to year_thou:year_hund.
  - Otherwise apply it to year_ten:year_unit.
- Run mode (mode_date = 1):
  - tick_day = 0: hold all fields; tick_millennium = 0.
  - tick_day = 1, day < mdays: day + 1, with BCD carry unit 9 -> 0, ten + 1.
  - tick_day = 1, day == mdays: day = 01; month + 1.
  - Month 12 wraps to 01 and increments the 4-digit BCD year with ripple carry.
  - Year 9999 -> 0000.
  - tick_millennium = 1 in the cycle after a year increment that changes year_thou, including the 9999 -> 0000 wrap; 0 on every other cycle.
- Set mode (mode_date = 0):
  - tick_day is ignored; tick_millennium = 0.
  - {up, down} = 10 increments the field selected by sel; 01 decrements it; 00 and 11 leave it unchanged.
  - Day: range 01..mdays(current month/year). Up at mdays -> 01; down at 01 -> mdays.
  - Month: up at 12 -> 01; down at 01 -> 12.
  - Year: up at 9999 -> 0000; down at 0000 -> 9999. No pulse is generated in set mode.
  - After a month or year change, if day > new mdays, day is clamped to new mdays in the same clock (e.g. 31-03 down-month -> 29-02 or 28-02).
  - sel = 11: no field changes.
- Invariants:
  - Day never reads 00 or exceeds mdays.
  - Month never reads 00 or exceeds 12.
  - No BCD digit ever exceeds 9.
- Mode switch mid-tick: mode is sampled with tick_day in the same cycle. A tick coinciding with mode_date = 0 is lost (decided).
- Reset mid-operation restores the reset date immediately (asynchronous) and clears tick_millennium.

Optional Feature:
- Macro: COUNTER_DATE_LEAP_YEAR_EN.
- Defined: leap rule as above; February has 29 days in leap years.
- Undefined: February is always 28 days and the leap logic is not synthesised. 28-02 + tick_day -> 01-03 in every year.

Decomposition:
- Shared package clock_pkg:
  - sel encodings: SEL_DAY, SEL_MONTH, SEL_YEAR, SEL_NONE.
  - BCD month constants.
  - Reset date constants.
- Sub-module date_limit (combinational):
  - Inputs: month BCD and year BCD.
  - Output: mdays as BCD ten/unit plus an is_leap flag.
  - Instantiated twice: once for the current date, once for the post-adjust month/year used by clamping.

Test Plan:
- Reset, then 31 tick_day pulses in run mode -> 01-02-2000; 28 more -> 29-02-2000 (2000 leap); 1 more -> 01-03-2000.
- Set mode, year = 1900, sel = month to 02, day to 28, then run with 1 tick -> 01-03-1900 (not leap). Repeat with 2024 -> 29-02-2024.
- Run mode, date 31-12-2999, tick_day -> 01-01-3000 and tick_millennium high for exactly one cycle. Repeat from 31-12-9999 -> 01-01-0000 with a pulse.
- Set mode, date 31-03-2023, sel = month, down one cycle -> 28-02-2023. Then sel = day, up -> 01-02-2023. Then down -> 28-02-2023.
- Set mode with up = down = 1, and with sel = 11 -> no change over 10 cycles. tick_day pulses in set mode -> no change, no tick_millennium.
- Assert rst_n low asynchronously mid-run at 15-07-2345 -> outputs read 01-01-2000 before the next clk edge. Without COUNTER_DATE_LEAP_YEAR_EN, 28-02-2000 + tick -> 01-03-2000.
